minimig_sram_arbiter: RTL and testbench
=======================================

Name: minimig_sram_arbiter

Overview:
- Shares the single SRAM bridge between the chipset bus and a secondary host port (OSD/loader/debug DMA).
- The chipset always owns its bus slot. The host port only uses 7 MHz slots in which the chipset bank select is all-zero.
- The block sequences host accesses inside the Q0..Q3 phase frame given by c1/c3, and flags host starvation so the CPU can be throttled upstream.

Parameters:
- HOST_BANK, 8'h01, bank vector driven to the bridge during host slots (chip-RAM path, so the address passes through unmodified).
- MAX_WAIT, 15, number of denied slots after which host_starve asserts; 4-bit saturating counter.

Ports:
- clk  in  1  28 MHz system clock
- _reset  in  1  asynchronous active-low reset
- c1  in  1  clock enable, phase reference
- c3  in  1  clock enable, phase reference
- chip_bank  in  8  chipset bank select
- chip_addr  in  23 (bits 23:1)  chipset address
- chip_wdata  in  16  chipset write data
- chip_rd  in  1  chipset read strobe
- chip_hwr  in  1  chipset high-byte write strobe
- chip_lwr  in  1  chipset low-byte write strobe
- chip_rdata  out  16  chipset read data; 0 during host slots
- host_req  in  1  one-clk request strobe
- host_we  in  1  1 = write
- host_be  in  2  byte enables {hi,lo}
- host_addr  in  22 (bits 22:1)  host word address
- host_wdata  in  16  host write data
- host_rdata  out  16  registered read data
- host_busy  out  1  request accepted, not yet acked
- host_ack  out  1  one-clk completion pulse
- host_starve  out  1  wait counter saturated
- br_bank  out  8  to bridge bank
- br_addr  out  23 (bits 23:1)  to bridge address_in
- br_wdata  out  16  to bridge data_in
- br_rd  out  1  to bridge rd
- br_hwr  out  1  to bridge hwr
- br_lwr  out  1  to bridge lwr
- br_rdata  in  16  from bridge data_out

Behaviour:
- Clock and reset: one clock, clk; reset _reset is asynchronous and active-low.
- Phase decode (combinational, from live {c1,c3}):
  - Q0 = 10
  - Q1 = 11
  - Q2 = 01
  - Q3 = 00
- Reset values:
  - state IDLE; all host registers 0.
  - host_busy/host_ack/host_starve 0; host_rdata 0; wait_cnt 0.
  - Bridge mux selects the chipset, so br_* equal the chip_* inputs.
- State machine:
  - IDLE: on host_req, latch we/be/addr/wdata, then go to WAIT. host_busy=1 from the next clk.
  - WAIT: at a clk edge with phase==Q0:
    - if chip_bank==0, go to ACCESS;
    - else wait_cnt = min(wait_cnt+1, MAX_WAIT).
  - ACCESS (phases Q1..Q3 of the granted slot):
    - br_bank = HOST_BANK, br_addr = {1'b0, latched addr}, br_wdata = latched data.
    - Read: br_rd=1 in Q1..Q3.
    - Write: br_hwr=be[1] and br_lwr=be[0] in Q1..Q2 only; both 0 in Q3 for data hold.
    - At the edge ending Q3: capture br_rdata into host_rdata (reads only; writes leave host_rdata unchanged), then go to DONE.
  - DONE: host_ack=1 for exactly one clk; host_busy=0, wait_cnt=0; go to IDLE.
- Pass-through:
  - Outside ACCESS: br_* = chip_*, and chip_rdata = br_rdata.
  - In ACCESS: chip_rdata = 0, and chip strobes are not forwarded.
- host_starve = (wait_cnt == MAX_WAIT). It clears only in DONE or on reset.
- Boundary conditions:
  - host_req while busy: ignored, no latch, no error.
  - host_req in the same clk as host_ack: ignored; the requester re-issues.
  - Grant needs chip_bank==0 at the Q0 edge. The upstream guarantees chip_bank is stable for a whole slot. A nonzero chip_bank during ACCESS is ignored; the host slot completes.
  - host_be==0 on a write: the slot is still consumed with no strobes, and the ack is still issued.
  - Async reset mid-ACCESS: the mux returns to chipset immediately, so no truncated write is forwarded after release.
- Latency: request to ack is at least 6 clks when the next slot is free.

Decomposition:
- Shared package minimig_sram_pkg:
  - phase encodings Q0..Q3;
  - state enum IDLE/WAIT/ACCESS/DONE;
  - HOST_BANK default.
- One natural sub-module: minimig_sram_phase. It decodes c1/c3 into a one-hot phase and a slot_start pulse, and is reusable by other bridge users.

Test Plan:
- Idle chipset (chip_bank=0), host read at 22'h0ABCDE; bridge model returns 16'h1234 → br_bank=8'h01, br_rd high Q1..Q3, host_rdata=16'h1234, host_ack one clk, at least 6 clks after req.
- Host write be=2'b10, data 16'hBEEF → br_hwr high Q1..Q2 only, br_lwr never high, br_wdata=16'hBEEF, ack issued.
- chip_bank=8'h01 every slot for 20 slots with host pending → no host strobes; host_starve=1 after 15 slots; chipset traffic unaltered; on first free slot the access completes and host_starve clears.
- Chipset read with bridge returning 16'h5A5A, no host activity → chip_rdata=16'h5A5A; br_* identical to chip_* every clk.
- Second host_req while busy → ignored; exactly one ack; latched address unchanged.
- Assert _reset low during Q1 of a host write → br_hwr/br_lwr drop asynchronously; after release state is IDLE, busy=0, no ack.

Source files
------------

// File: rtl/minimig_sram_pkg.sv
// Shared definitions for the SRAM bridge arbiter: 7 MHz phase codes,
// arbiter states and the default bank used for host slots.
package minimig_sram_pkg;

  // {c1,c3} encodings of the four 28 MHz phases inside one 7 MHz slot
  typedef enum logic [1:0] {
    PH_Q0 = 2'b10,
    PH_Q1 = 2'b11,
    PH_Q2 = 2'b01,
    PH_Q3 = 2'b00
  } phase_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  // Bit positions in the one-hot phase vector
  localparam int Q0 = 0;
  localparam int Q1 = 1;
  localparam int Q2 = 2;
  localparam int Q3 = 3;

  localparam logic [7:0] HOST_BANK_DEFAULT = 8'h01;
  localparam int unsigned MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/minimig_sram_phase.sv
// Decodes the c1/c3 phase references into a one-hot Q0..Q3 vector and a
// slot_start strobe marking the Q0 phase of each 7 MHz slot.
module minimig_sram_phase
  import minimig_sram_pkg::*;
(
  input  logic       c1,
  input  logic       c3,
  output logic [3:0] phase,
  output logic       slot_start
);

  always_comb begin
    phase = '0;
    case (phase_t'({c1, c3}))
      PH_Q0: phase[Q0] = 1'b1;
      PH_Q1: phase[Q1] = 1'b1;
      PH_Q2: phase[Q2] = 1'b1;
      PH_Q3: phase[Q3] = 1'b1;
    endcase
  end

  assign slot_start = phase[Q0];

endmodule

// File: rtl/minimig_sram_arbiter.sv
// Shares the SRAM bridge between the chipset and a host port: the host only
// uses slots whose chipset bank select is all-zero, and reports starvation.
module minimig_sram_arbiter
  import minimig_sram_pkg::*;
#(
  parameter logic [7:0]  HOST_BANK = HOST_BANK_DEFAULT,
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        c1,
  input  logic        c3,
  input  logic [7:0]  chip_bank,
  input  logic [23:1] chip_addr,
  input  logic [15:0] chip_wdata,
  input  logic        chip_rd,
  input  logic        chip_hwr,
  input  logic        chip_lwr,
  output logic [15:0] chip_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [1:0]  host_be,
  input  logic [22:1] host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_busy,
  output logic        host_ack,
  output logic        host_starve,
  output logic [7:0]  br_bank,
  output logic [23:1] br_addr,
  output logic [15:0] br_wdata,
  output logic        br_rd,
  output logic        br_hwr,
  output logic        br_lwr,
  input  logic [15:0] br_rdata
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [3:0]  phase;
  logic        slot_start;
  logic        lat_we;
  logic [1:0]  lat_be;
  logic [22:1] lat_addr;
  logic [15:0] lat_wdata;
  logic [3:0]  wait_cnt;

  minimig_sram_phase u_phase (
    .c1         (c1),
    .c3         (c3),
    .phase      (phase),
    .slot_start (slot_start)
  );

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    host_busy = 1'b0;
    host_ack  = 1'b0;
    unique case (state)
      IDLE: if (host_req) state_nxt = WAIT;
      WAIT: begin
        host_busy = 1'b1;
        if (slot_start && chip_bank == 8'h00) state_nxt = ACCESS;
      end
      ACCESS: begin
        host_busy = 1'b1;
        if (phase[Q3]) state_nxt = DONE;
      end
      DONE: begin
        host_ack  = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, read capture and the saturating denied-slot counter;
  // the counter clears on the edge into DONE so starve drops with the ack.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      host_rdata <= '0;
      wait_cnt   <= '0;
    end else begin
      if (state == IDLE && host_req) begin
        lat_we    <= host_we;
        lat_be    <= host_be;
        lat_addr  <= host_addr;
        lat_wdata <= host_wdata;
      end
      if (state == WAIT && slot_start && chip_bank != 8'h00 && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 4'd1;
      if (state == ACCESS && phase[Q3]) begin
        if (!lat_we) host_rdata <= br_rdata;
        wait_cnt <= '0;
      end
    end
  end

  assign host_starve = (wait_cnt == WAIT_MAX);

  // Write strobes stop after Q2 so the data stays stable through Q3.
  always_comb begin
    br_bank    = chip_bank;
    br_addr    = chip_addr;
    br_wdata   = chip_wdata;
    br_rd      = chip_rd;
    br_hwr     = chip_hwr;
    br_lwr     = chip_lwr;
    chip_rdata = br_rdata;
    if (state == ACCESS) begin
      br_bank    = HOST_BANK;
      br_addr    = {1'b0, lat_addr};
      br_wdata   = lat_wdata;
      br_rd      = !lat_we && !phase[Q0];
      br_hwr     = lat_we && lat_be[1] && (phase[Q1] || phase[Q2]);
      br_lwr     = lat_we && lat_be[0] && (phase[Q1] || phase[Q2]);
      chip_rdata = '0;
    end
  end

endmodule

// File: tb/tb_minimig_sram_arbiter.sv
// Self-checking bench for minimig_sram_arbiter: directed scenarios plus random
// traffic, checked every clk against a slot-level reference model.
module tb_minimig_sram_arbiter;

  logic        clk = 1'b0;
  logic        _reset;
  logic        c1, c3;
  logic [7:0]  chip_bank;
  logic [23:1] chip_addr;
  logic [15:0] chip_wdata;
  logic        chip_rd, chip_hwr, chip_lwr;
  logic [15:0] chip_rdata;
  logic        host_req, host_we;
  logic [1:0]  host_be;
  logic [22:1] host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        host_busy, host_ack, host_starve;
  logic [7:0]  br_bank;
  logic [23:1] br_addr;
  logic [15:0] br_wdata;
  logic        br_rd, br_hwr, br_lwr;
  logic [15:0] br_rdata;

  always #5 clk = ~clk;

  minimig_sram_arbiter dut (
    .clk(clk), ._reset(_reset), .c1(c1), .c3(c3),
    .chip_bank(chip_bank), .chip_addr(chip_addr), .chip_wdata(chip_wdata),
    .chip_rd(chip_rd), .chip_hwr(chip_hwr), .chip_lwr(chip_lwr), .chip_rdata(chip_rdata),
    .host_req(host_req), .host_we(host_we), .host_be(host_be), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_busy(host_busy),
    .host_ack(host_ack), .host_starve(host_starve),
    .br_bank(br_bank), .br_addr(br_addr), .br_wdata(br_wdata),
    .br_rd(br_rd), .br_hwr(br_hwr), .br_lwr(br_lwr), .br_rdata(br_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ph = 0;

  // Reference model: one pending transaction, the cycle index of its granted
  // Q0, the denied-slot count and the last captured read word.
  logic        m_pending;
  int          m_grant;
  logic        m_we;
  logic [1:0]  m_be;
  logic [22:1] m_addr;
  logic [15:0] m_wdata, m_rdata;
  int          m_denied;
  int          req_cyc, ack_cyc;

  logic        drv_rst_n, drv_req, drv_we;
  logic [1:0]  drv_be;
  logic [22:1] drv_addr;
  logic [15:0] drv_wdata;
  logic [7:0]  slot_bank;
  logic        rand_chip, fix_rd_en;
  logic [15:0] fix_rd;
  int          acc_rd_cnt, acc_hwr_cnt, acc_lwr_cnt, ack_cnt;
  logic [23:1] acc_addr;
  logic [15:0] acc_wdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pending = 1'b0;
    m_grant   = -1;
    m_we      = 1'b0;
    m_be      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    m_rdata   = '0;
    m_denied  = 0;
  endtask

  task automatic clearCounters();
    acc_rd_cnt  = 0;
    acc_hwr_cnt = 0;
    acc_lwr_cnt = 0;
    ack_cnt     = 0;
  endtask

  // Apply the rules to the clk that just ended (inputs still hold its values).
  task automatic modelEdge();
    if (!_reset) modelReset();
    else if (m_pending && m_grant >= 0 && cyc == m_grant + 4) begin
      m_pending = 1'b0;
      m_grant   = -1;
    end else if (m_pending) begin
      if (m_grant < 0) begin
        if (ph == 0) begin
          if (chip_bank == 8'h00) m_grant = cyc;
          else if (m_denied < 15) m_denied++;
        end
      end else if (cyc == m_grant + 3) begin
        if (!m_we) m_rdata = br_rdata;
        m_denied = 0;
      end
    end else if (host_req) begin
      m_pending = 1'b1;
      m_we      = host_we;
      m_be      = host_be;
      m_addr    = host_addr;
      m_wdata   = host_wdata;
      req_cyc   = cyc;
    end
  endtask

  task automatic checkCycle();
    int   off;
    logic acc, ack_e;
    off   = (m_grant >= 0) ? cyc - m_grant : -1;
    acc   = (off >= 1 && off <= 3);
    ack_e = (off == 4);
    checkOutput("host_ack", 32'(host_ack), 32'(ack_e));
    checkOutput("host_busy", 32'(host_busy), 32'(m_pending && !ack_e));
    checkOutput("host_starve", 32'(host_starve), 32'(m_denied == 15));
    checkOutput("host_rdata", 32'(host_rdata), 32'(m_rdata));
    if (acc) begin
      checkOutput("acc_bank", 32'(br_bank), 32'h01);
      checkOutput("acc_addr", 32'(br_addr), 32'({1'b0, m_addr}));
      checkOutput("acc_wdata", 32'(br_wdata), 32'(m_wdata));
      checkOutput("acc_rd", 32'(br_rd), 32'(!m_we));
      checkOutput("acc_hwr", 32'(br_hwr), 32'(m_we && m_be[1] && off <= 2));
      checkOutput("acc_lwr", 32'(br_lwr), 32'(m_we && m_be[0] && off <= 2));
      checkOutput("acc_chip_rdata", 32'(chip_rdata), 32'h0);
      acc_rd_cnt  += int'(br_rd);
      acc_hwr_cnt += int'(br_hwr);
      acc_lwr_cnt += int'(br_lwr);
      acc_addr  = br_addr;
      acc_wdata = br_wdata;
    end else begin
      checkOutput("pass_bank", 32'(br_bank), 32'(chip_bank));
      checkOutput("pass_addr", 32'(br_addr), 32'(chip_addr));
      checkOutput("pass_wdata", 32'(br_wdata), 32'(chip_wdata));
      checkOutput("pass_strobes", 32'({br_rd, br_hwr, br_lwr}), 32'({chip_rd, chip_hwr, chip_lwr}));
      checkOutput("pass_rdata", 32'(chip_rdata), 32'(br_rdata));
    end
    if (host_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
  endtask

  // One 28 MHz clk: model the edge, drive the next phase's inputs, check at negedge.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    cyc++;
    ph = cyc % 4;
    _reset = drv_rst_n;
    case (ph)
      0:       {c1, c3} = 2'b10;
      1:       {c1, c3} = 2'b11;
      2:       {c1, c3} = 2'b01;
      default: {c1, c3} = 2'b00;
    endcase
    if (ph == 0) chip_bank = slot_bank;
    if (rand_chip) begin
      chip_addr  = 23'($urandom);
      chip_wdata = 16'($urandom);
      chip_rd    = 1'($urandom);
      chip_hwr   = 1'($urandom);
      chip_lwr   = 1'($urandom);
    end else begin
      chip_rd  = 1'b0;
      chip_hwr = 1'b0;
      chip_lwr = 1'b0;
    end
    br_rdata = fix_rd_en ? fix_rd : 16'($urandom);
    host_req = drv_req;
    if (drv_req) begin
      host_we    = drv_we;
      host_be    = drv_be;
      host_addr  = drv_addr;
      host_wdata = drv_wdata;
    end else begin
      host_we    = 1'($urandom);
      host_be    = 2'($urandom);
      host_addr  = 22'($urandom);
      host_wdata = 16'($urandom);
    end
    drv_req = 1'b0;
    @(negedge clk);
    checkCycle();
  endtask

  task automatic issueReq(input logic we, input logic [1:0] be, input logic [22:1] addr,
                          input logic [15:0] wd);
    drv_req   = 1'b1;
    drv_we    = we;
    drv_be    = be;
    drv_addr  = addr;
    drv_wdata = wd;
  endtask

  task automatic waitAck(input string tag, input int limit);
    logic got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      applyStimulus();
      if (host_ack) got = 1'b1;
    end
    checkOutput(tag, 32'(got), 32'h1);
  endtask

  initial begin
    logic got;
    _reset = 1'b0; drv_rst_n = 1'b0; {c1, c3} = 2'b10;
    chip_bank = '0; chip_addr = '0; chip_wdata = '0;
    chip_rd = 1'b0; chip_hwr = 1'b0; chip_lwr = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_be = '0; host_addr = '0; host_wdata = '0;
    br_rdata = '0; drv_req = 1'b0; drv_we = 1'b0; drv_be = '0; drv_addr = '0; drv_wdata = '0;
    slot_bank = '0; rand_chip = 1'b0; fix_rd_en = 1'b0; fix_rd = '0;
    req_cyc = 0; ack_cyc = 0; acc_addr = '0; acc_wdata = '0;
    modelReset();
    clearCounters();

    $display("[TB] reset state");
    repeat (3) applyStimulus();
    checkOutput("rst_busy", 32'(host_busy), 32'h0);
    checkOutput("rst_ack", 32'(host_ack), 32'h0);
    checkOutput("rst_rdata", 32'(host_rdata), 32'h0);
    drv_rst_n = 1'b1;
    repeat (4) applyStimulus();

    $display("[TB] host read, free chipset");
    fix_rd_en = 1'b1; fix_rd = 16'h1234; clearCounters();
    issueReq(1'b0, 2'b11, 22'h0ABCDE, 16'h0000);
    waitAck("rd_ack_timeout", 40);
    checkOutput("rd_data", 32'(host_rdata), 32'h1234);
    checkOutput("rd_strobe_clks", 32'(acc_rd_cnt), 32'd3);
    checkOutput("rd_addr", 32'(acc_addr), 32'h0ABCDE);
    checkOutput("rd_latency_ge6", 32'((ack_cyc - req_cyc + 1) >= 6), 32'h1);
    repeat (3) applyStimulus();
    checkOutput("rd_single_ack", 32'(ack_cnt), 32'd1);

    $display("[TB] host write be=10");
    fix_rd_en = 1'b0; clearCounters();
    issueReq(1'b1, 2'b10, 22'h155AA0, 16'hBEEF);
    waitAck("wr_ack_timeout", 40);
    checkOutput("wr_hwr_clks", 32'(acc_hwr_cnt), 32'd2);
    checkOutput("wr_lwr_clks", 32'(acc_lwr_cnt), 32'd0);
    checkOutput("wr_wdata", 32'(acc_wdata), 32'hBEEF);
    checkOutput("wr_rdata_kept", 32'(host_rdata), 32'h1234);

    $display("[TB] write with no byte enables");
    clearCounters();
    issueReq(1'b1, 2'b00, 22'h000010, 16'hCAFE);
    waitAck("be0_ack_timeout", 40);
    checkOutput("be0_strobes", 32'(acc_hwr_cnt + acc_lwr_cnt), 32'd0);

    $display("[TB] starvation by busy chipset");
    rand_chip = 1'b1; slot_bank = 8'h01; clearCounters();
    repeat (4) applyStimulus();
    issueReq(1'b0, 2'b11, 22'h3FFFFF, 16'h0000);
    repeat (80) applyStimulus();
    checkOutput("starve_set", 32'(host_starve), 32'h1);
    checkOutput("starve_no_access", 32'(acc_rd_cnt), 32'd0);
    checkOutput("starve_busy", 32'(host_busy), 32'h1);
    slot_bank = 8'h00;
    waitAck("starve_ack_timeout", 20);
    checkOutput("starve_cleared", 32'(host_starve), 32'h0);

    $display("[TB] chipset read pass-through");
    fix_rd_en = 1'b1; fix_rd = 16'h5A5A;
    repeat (4) applyStimulus();
    checkOutput("chip_rdata", 32'(chip_rdata), 32'h5A5A);
    fix_rd_en = 1'b0;

    $display("[TB] request while busy");
    clearCounters();
    issueReq(1'b0, 2'b11, 22'h012345, 16'h0000);
    repeat (2) applyStimulus();
    issueReq(1'b0, 2'b11, 22'h2AAAAA, 16'h0000);
    waitAck("busy_ack_timeout", 40);
    repeat (8) applyStimulus();
    checkOutput("busy_one_ack", 32'(ack_cnt), 32'd1);
    checkOutput("busy_addr_kept", 32'(acc_addr), 32'h012345);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if (((cyc + 1) % 4) == 0)
        slot_bank = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom_range(0, 5) == 0)
        issueReq(1'($urandom), 2'($urandom), 22'($urandom), 16'($urandom));
      applyStimulus();
    end
    slot_bank = 8'h00;
    repeat (12) applyStimulus();

    $display("[TB] reset during host write");
    rand_chip = 1'b0; clearCounters();
    issueReq(1'b1, 2'b11, 22'h0F0F0F, 16'h1357);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      applyStimulus();
      if (m_grant >= 0 && cyc == m_grant + 1) got = 1'b1;
    end
    checkOutput("rst_reach_q1", 32'(got), 32'h1);
    checkOutput("rst_pre_hwr", 32'(br_hwr), 32'h1);
    #1;
    _reset = 1'b0; drv_rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_async_hwr", 32'(br_hwr), 32'h0);
    checkOutput("rst_async_lwr", 32'(br_lwr), 32'h0);
    checkOutput("rst_async_bank", 32'(br_bank), 32'(chip_bank));
    checkOutput("rst_async_busy", 32'(host_busy), 32'h0);
    repeat (2) applyStimulus();
    drv_rst_n = 1'b1;
    clearCounters();
    repeat (10) applyStimulus();
    checkOutput("rst_no_ack", 32'(ack_cnt), 32'd0);
    checkOutput("rst_idle_busy", 32'(host_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
